// File: rtl/uart_tx_param_if.sv
// Transmit-side bus of uart_tx_param: word handshake, serial line and status.
// A word moves on a rising edge where en && ready; data_in only matters on that edge,
// and en raised while ready is low is simply ignored (no stall, no queueing).
interface uart_tx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 en;
   logic [DATA_BITS-1:0] data_in;
   logic                 ready;
   logic                 tx;
   logic                 busy;
   logic                 done;
   logic [2:0]           state_dbg;

   modport master (
      output en, data_in,
      input  ready, tx, busy, done, state_dbg
   );

   modport slave (
      input  en, data_in,
      output ready, tx, busy, done, state_dbg
   );
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: 1-deep holding register, shift register and
// a frame FSM with its own bit-period counter; tx, done are registered outputs.
module uart_tx_param #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input logic            clk,
   input logic            rst,
   uart_tx_param_if.slave bus
);

   localparam int CLKS_PER_BIT = (BAUD > 0) ? (CLK_FREQ / BAUD) : 0;
   localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
   localparam logic             HAS_PARITY = (PARITY != 0);
   localparam logic             ODD_PARITY = (PARITY == 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_rate
         $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_param: DATA_BITS must be 5..9");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx_param: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx_param: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_valid_q, hold_valid_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;

   logic bit_end;
   logic accept;
   logic load;

   assign bit_end = (cnt_q == CNT_LAST);
   assign accept  = bus.en && !hold_valid_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = bit_end ? '0 : cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      par_d        = par_q;
      done_d       = 1'b0;
      load         = 1'b0;

      if (accept) begin
         hold_d       = bus.data_in;
         hold_valid_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            load  = hold_valid_q;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = HAS_PARITY ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               idx_d   = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (idx_q == STOP_LAST) begin
                  done_d = 1'b1;
                  if (hold_valid_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // Hold-to-shift transfer; ready is low on this edge so it never races an accept.
      if (load) begin
         state_d      = S_START;
         cnt_d        = '0;
         idx_d        = '0;
         shift_d      = hold_q;
         par_d        = ODD_PARITY ? ~(^hold_q) : (^hold_q);
         hold_valid_d = 1'b0;
      end
   end

   // tx follows the state one cycle late, so every bit on the line is exactly one period.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_q[0];
         S_PARITY: tx_d = par_q;
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         par_q        <= 1'b0;
         tx_q         <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         par_q        <= par_d;
         tx_q         <= tx_d;
         done_q       <= done_d;
      end
   end

   assign bus.ready     = !hold_valid_q;
   assign bus.tx        = tx_q;
   assign bus.busy      = (state_q != S_IDLE) || hold_valid_q;
   assign bus.done      = done_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param at 10 clocks per bit in four frame formats
// (8N1, 7E2, 7O2, 9O1); each scenario task checks the captured line inline.
module tb_uart_tx_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_param_if #(.DATA_BITS(8)) b8  ();
   uart_tx_param_if #(.DATA_BITS(7)) b7e ();
   uart_tx_param_if #(.DATA_BITS(7)) b7o ();
   uart_tx_param_if #(.DATA_BITS(9)) b9  ();

   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
      u_8n1 (.clk(clk), .rst(rst), .bus(b8.slave));
   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
      u_7e2 (.clk(clk), .rst(rst), .bus(b7e.slave));
   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
      u_7o2 (.clk(clk), .rst(rst), .bus(b7o.slave));
   uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1))
      u_9o1 (.clk(clk), .rst(rst), .bus(b9.slave));

   int n_checks = 0;
   int n_fail   = 0;

   // Line selector for the capture task: 0=8N1, 1=7E2, 2=7O2, 3=9O1.
   int   sel = 0;
   logic tx_sel, done_sel, rdy_sel;
   always_comb begin
      case (sel)
         1:       begin tx_sel = b7e.tx; done_sel = b7e.done; rdy_sel = b7e.ready; end
         2:       begin tx_sel = b7o.tx; done_sel = b7o.done; rdy_sel = b7o.ready; end
         3:       begin tx_sel = b9.tx;  done_sel = b9.done;  rdy_sel = b9.ready;  end
         default: begin tx_sel = b8.tx;  done_sel = b8.done;  rdy_sel = b8.ready;  end
      endcase
   end

   logic line_s [0:255];
   logic done_s [0:255];
   logic rdy_s  [0:255];

   // Called on a negedge: waits for the start bit, then records len samples, one per negedge.
   task automatic capture(input int max_wait, input int len, output int waited, output bit timeout);
      waited  = 0;
      timeout = 1'b0;
      while (tx_sel !== 1'b0 && waited < max_wait) begin
         @(negedge clk);
         waited++;
      end
      if (tx_sel !== 1'b0) begin
         timeout = 1'b1;
         return;
      end
      for (int i = 0; i < len; i++) begin
         if (i > 0) @(negedge clk);
         line_s[i] = tx_sel;
         done_s[i] = done_sel;
         rdy_s[i]  = rdy_sel;
      end
   endtask

   task automatic send_8(input logic [7:0] w);
      @(negedge clk);
      b8.data_in = w;
      b8.en      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.en      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (b8.tx !== 1'b1)        begin n_fail++; $display("FAIL reset_tx_8n1: got %b want 1", b8.tx); end
      n_checks++; if (b8.ready !== 1'b1)     begin n_fail++; $display("FAIL reset_ready_8n1: got %b want 1", b8.ready); end
      n_checks++; if (b8.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy_8n1: got %b want 0", b8.busy); end
      n_checks++; if (b8.done !== 1'b0)      begin n_fail++; $display("FAIL reset_done_8n1: got %b want 0", b8.done); end
      n_checks++; if (b8.state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state_8n1: got %0d want 0", b8.state_dbg); end
      n_checks++; if (b7e.tx !== 1'b1 || b7o.tx !== 1'b1 || b9.tx !== 1'b1)
         begin n_fail++; $display("FAIL reset_tx_others: got %b%b%b want 111", b7e.tx, b7o.tx, b9.tx); end
      n_checks++; if (b7e.busy !== 1'b0 || b7o.busy !== 1'b0 || b9.busy !== 1'b0)
         begin n_fail++; $display("FAIL reset_busy_others: got %b%b%b want 000", b7e.busy, b7o.busy, b9.busy); end
      rst = 1'b0;
   endtask

   task automatic test_8n1_frame();
      logic [15:0] exp_bits;
      int w; bit to;
      exp_bits = 16'b0000_0011_0100_1010;  // 0,1,0,1,0,0,1,0,1,1 for 8'hA5
      sel = 0;
      send_8(8'hA5);
      n_checks++; if (b8.ready !== 1'b0) begin n_fail++; $display("FAIL a5_ready_after_accept: got %b want 0", b8.ready); end
      n_checks++; if (b8.busy !== 1'b1)  begin n_fail++; $display("FAIL a5_busy_after_accept: got %b want 1", b8.busy); end
      capture(20, 100, w, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL a5_start_timeout: got %b want 0", to); return; end
      n_checks++; if (w !== 2) begin n_fail++; $display("FAIL a5_latency: got %0d want 2", w); end
      for (int i = 0; i < 100; i++) begin
         n_checks++; if (line_s[i] !== exp_bits[i/10]) begin n_fail++; $display("FAIL a5_line[%0d]: got %b want %b", i, line_s[i], exp_bits[i/10]); end
         n_checks++; if (done_s[i] !== (i == 99)) begin n_fail++; $display("FAIL a5_done[%0d]: got %b want %b", i, done_s[i], (i == 99)); end
      end
      @(negedge clk);
      n_checks++; if (b8.busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_after: got %b want 0", b8.busy); end
      n_checks++; if (b8.tx !== 1'b1)   begin n_fail++; $display("FAIL a5_tx_after: got %b want 1", b8.tx); end
      n_checks++; if (b8.done !== 1'b0) begin n_fail++; $display("FAIL a5_done_after: got %b want 0", b8.done); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_a, exp_b;
      int w; bit to; bit saw_low;
      exp_a = 16'b0000_0011_0100_1010;  // 8'hA5
      exp_b = 16'b0000_0010_0111_1000;  // 0,0,0,1,1,1,1,0,0,1 for 8'h3C
      sel = 0;
      send_8(8'hA5);
      fork
         capture(20, 200, w, to);
         begin
            repeat (20) @(negedge clk);
            n_checks++; if (b8.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_before_second: got %b want 1", b8.ready); end
            b8.data_in = 8'h3C;
            b8.en      = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (b8.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held: got %b want 0", b8.ready); end
            b8.data_in = 8'h77;
            repeat (30) @(negedge clk);
            b8.en = 1'b0;
         end
      join
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_start_timeout: got %b want 0", to); return; end
      n_checks++; if (w !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", w); end
      for (int i = 0; i < 200; i++) begin
         if (i < 100) begin
            n_checks++; if (line_s[i] !== exp_a[i/10]) begin n_fail++; $display("FAIL b2b_line_a[%0d]: got %b want %b", i, line_s[i], exp_a[i/10]); end
         end else begin
            n_checks++; if (line_s[i] !== exp_b[(i-100)/10]) begin n_fail++; $display("FAIL b2b_line_b[%0d]: got %b want %b", i, line_s[i], exp_b[(i-100)/10]); end
         end
         n_checks++; if (done_s[i] !== (i == 99 || i == 199)) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b", i, done_s[i]); end
      end
      n_checks++; if (rdy_s[98] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_before_start2: got %b want 0", rdy_s[98]); end
      n_checks++; if (rdy_s[99] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_at_start2: got %b want 1", rdy_s[99]); end
      saw_low = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (b8.tx !== 1'b1) saw_low = 1'b1;
      end
      n_checks++; if (saw_low !== 1'b0) begin n_fail++; $display("FAIL b2b_third_word_sent: got tx low want idle"); end
      n_checks++; if (b8.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b want 0", b8.busy); end
   endtask

   task automatic test_parity_7bit();
      logic [15:0] exp_bits;
      int w; bit to;
      for (int k = 0; k < 2; k++) begin
         sel = k + 1;
         // 7'h55: 0,1,0,1,0,1,0,1,par,1,1 ; even parity 0, odd parity 1
         exp_bits = (k == 0) ? 16'b0000_0110_1010_1010 : 16'b0000_0111_1010_1010;
         @(negedge clk);
         if (k == 0) begin b7e.data_in = 7'h55; b7e.en = 1'b1; end
         else        begin b7o.data_in = 7'h55; b7o.en = 1'b1; end
         @(posedge clk);
         @(negedge clk);
         b7e.en = 1'b0;
         b7o.en = 1'b0;
         capture(20, 110, w, to);
         n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL p7_%0d_start_timeout: got %b want 0", k, to); continue; end
         n_checks++; if (w !== 2) begin n_fail++; $display("FAIL p7_%0d_latency: got %0d want 2", k, w); end
         for (int i = 0; i < 110; i++) begin
            n_checks++; if (line_s[i] !== exp_bits[i/10]) begin n_fail++; $display("FAIL p7_%0d_line[%0d]: got %b want %b", k, i, line_s[i], exp_bits[i/10]); end
            n_checks++; if (done_s[i] !== (i == 109)) begin n_fail++; $display("FAIL p7_%0d_done[%0d]: got %b", k, i, done_s[i]); end
         end
         @(negedge clk);
         n_checks++; if (tx_sel !== 1'b1) begin n_fail++; $display("FAIL p7_%0d_tx_after: got %b want 1", k, tx_sel); end
      end
   endtask

   task automatic test_nine_bit_odd();
      logic [15:0] exp_bits;
      logic [8:0]  rx_word;
      logic        rx_par;
      int w; bit to; int rx_err;
      exp_bits = 16'b0000_1011_1111_1110;  // 0, nine 1s, parity 0, stop 1
      sel = 3;
      @(negedge clk);
      b9.data_in = 9'h1FF;
      b9.en      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b9.en = 1'b0;
      capture(20, 120, w, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL n9_start_timeout: got %b want 0", to); return; end
      n_checks++; if (w !== 2) begin n_fail++; $display("FAIL n9_latency: got %0d want 2", w); end
      for (int i = 0; i < 120; i++) begin
         n_checks++; if (line_s[i] !== exp_bits[i/10]) begin n_fail++; $display("FAIL n9_line[%0d]: got %b want %b", i, line_s[i], exp_bits[i/10]); end
         n_checks++; if (done_s[i] !== (i == 119)) begin n_fail++; $display("FAIL n9_done[%0d]: got %b", i, done_s[i]); end
      end
      // Mid-bit receiver: start, 9 data, odd parity, stop.
      rx_err = 0;
      if (line_s[5] !== 1'b0) rx_err++;
      for (int b = 0; b < 9; b++) rx_word[b] = line_s[15 + 10*b];
      rx_par = line_s[105];
      if ((^{rx_word, rx_par}) !== 1'b1) rx_err++;
      if (line_s[115] !== 1'b1) rx_err++;
      if (rx_word !== 9'h1FF) rx_err++;
      n_checks++; if (rx_err !== 0) begin n_fail++; $display("FAIL n9_receiver: got %0d errors want 0", rx_err); end
      n_checks++; if (rx_par !== 1'b0) begin n_fail++; $display("FAIL n9_parity_bit: got %b want 0", rx_par); end
      n_checks++; if (rx_word !== 9'h1FF) begin n_fail++; $display("FAIL n9_word: got %h want 1ff", rx_word); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] exp_bits;
      int w; bit to; bit bad;
      exp_bits = 16'b0000_0010_0001_1110;  // 8'h0F: 0,1,1,1,1,0,0,0,0,1
      sel = 0;
      send_8(8'hFF);
      capture(20, 1, w, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_start_timeout: got %b want 0", to); return; end
      repeat (20) @(negedge clk);
      b8.data_in = 8'h12;
      b8.en      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.en = 1'b0;
      n_checks++; if (b8.ready !== 1'b0) begin n_fail++; $display("FAIL rmid_held: got ready %b want 0", b8.ready); end
      repeat (23) @(negedge clk);  // now in the middle of data bit 3
      n_checks++; if (b8.tx !== 1'b1) begin n_fail++; $display("FAIL rmid_bit3_value: got %b want 1", b8.tx); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (b8.tx !== 1'b1)    begin n_fail++; $display("FAIL rmid_tx: got %b want 1", b8.tx); end
      n_checks++; if (b8.busy !== 1'b0)  begin n_fail++; $display("FAIL rmid_busy: got %b want 0", b8.busy); end
      n_checks++; if (b8.ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", b8.ready); end
      n_checks++; if (b8.done !== 1'b0)  begin n_fail++; $display("FAIL rmid_done: got %b want 0", b8.done); end
      bad = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (b8.tx !== 1'b1 || b8.done !== 1'b0) bad = 1'b1;
      end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet_after: got activity want idle line"); end
      send_8(8'h0F);
      capture(20, 100, w, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_new_timeout: got %b want 0", to); return; end
      n_checks++; if (w !== 2) begin n_fail++; $display("FAIL rmid_new_latency: got %0d want 2", w); end
      for (int i = 0; i < 100; i++) begin
         n_checks++; if (line_s[i] !== exp_bits[i/10]) begin n_fail++; $display("FAIL rmid_new_line[%0d]: got %b want %b", i, line_s[i], exp_bits[i/10]); end
      end
      n_checks++; if (done_s[99] !== 1'b1) begin n_fail++; $display("FAIL rmid_new_done: got %b want 1", done_s[99]); end
      @(negedge clk);
   endtask

   task automatic test_en_with_rst();
      bit bad;
      @(negedge clk);
      b8.data_in = 8'h81;
      b8.en      = 1'b1;
      rst        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b8.en = 1'b0;
      rst   = 1'b0;
      n_checks++; if (b8.ready !== 1'b1)     begin n_fail++; $display("FAIL enrst_ready: got %b want 1", b8.ready); end
      n_checks++; if (b8.busy !== 1'b0)      begin n_fail++; $display("FAIL enrst_busy: got %b want 0", b8.busy); end
      n_checks++; if (b8.state_dbg !== 3'd0) begin n_fail++; $display("FAIL enrst_state: got %0d want 0", b8.state_dbg); end
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (b8.tx !== 1'b1 || b8.busy !== 1'b0) bad = 1'b1;
      end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL enrst_word_sent: got activity want idle line"); end
   endtask

   initial begin
      b8.en  = 1'b0; b8.data_in  = '0;
      b7e.en = 1'b0; b7e.data_in = '0;
      b7o.en = 1'b0; b7o.data_in = '0;
      b9.en  = 1'b0; b9.data_in  = '0;
      test_reset();
      test_8n1_frame();
      test_back_to_back();
      test_parity_7bit();
      test_nine_bit_odd();
      test_reset_mid_frame();
      test_en_with_rst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
